// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array edge feeders (west in_a now, north in_b later).
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  // Zero-flush length: the last west-edge element must cross every row and column.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int drain_cnt_width(input int rows, input int cols);
    return $clog2(rows + cols);
  endfunction

endpackage

// File: rtl/skew_line.sv
// One activation lane's delay line: DEPTH registers, output taken from the last stage.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge feeder for systolic_array: diagonally skews accepted activation vectors,
// inserts zero bubbles, flushes zeros after the last beat and pulses done.
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int ROW        = 4,
  parameter int COL        = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ROW*DATA_WIDTH-1:0] s_data,
  input  logic                      s_last,
  output logic [ROW*DATA_WIDTH-1:0] skew_a,
  output logic                      arr_load,
  output logic                      busy,
  output logic                      done
);

  localparam int DRAIN_CYCLES = drain_cycles(ROW, COL);
  localparam int CNT_W        = drain_cnt_width(ROW, COL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  feeder_state_e             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      s_ready_q, s_ready_d;
  logic                      arr_load_q, arr_load_d;
  logic [ROW*DATA_WIDTH-1:0] head_d;
  logic                      accept;
  logic                      drain_end;

  assign accept    = s_valid & s_ready_q;
  assign drain_end = (state_q == DRAIN) && (cnt_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    head_d  = '0;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          head_d  = s_data;
          state_d = s_last ? DRAIN : STREAM;
          if (s_last) begin
            cnt_d = CNT_LOAD;
          end
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Ready and load are registered off the next state so neither depends on s_valid.
    s_ready_d  = (state_d != DRAIN);
    arr_load_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      arr_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      arr_load_q <= arr_load_d;
    end
  end

  for (genvar i = 0; i < ROW; i++) begin : g_lane
    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_line (
      .clk  (clk),
      .rst  (rst),
      .din  (head_d[DATA_WIDTH*i +: DATA_WIDTH]),
      .dout (skew_a[DATA_WIDTH*i +: DATA_WIDTH])
    );
  end

  assign s_ready  = s_ready_q;
  assign arr_load = arr_load_q;
  assign busy     = (state_q != IDLE);
  assign done     = drain_end;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with ROW=4, COL=4, DATA_WIDTH=8.
module tb_systolic_skew_feeder;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [31:0] skew_a;
  logic        arr_load;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         when;
    int         lane;
    logic [7:0] val;
  } sb_t;

  sb_t sb[$];

  systolic_skew_feeder #(
    .ROW        (4),
    .COL        (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .skew_a   (skew_a),
    .arr_load (arr_load),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Beat about to be accepted on the next edge: lane i must appear i edges after that.
  task automatic push_beat(input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{cyc + 1 + i, i, d[8*i +: 8]});
    end
  endtask

  task automatic pop_expected(input int when, output logic [31:0] v);
    v = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].when == when) begin
        v[8*sb[j].lane +: 8] = sb[j].val;
        sb.delete(j);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'hFFEEDDCC;
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++;
    if (skew_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_skew_a got=%h exp=0", skew_a); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (arr_load !== 1'b0 || done !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_load_done got=%b%b exp=00", arr_load, done);
    end
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_s_ready got=%b exp=1", s_ready); end
    checks++;
    if (busy !== 1'b0 || skew_a !== 32'h0) begin
      failures++; $display("[TB] FAIL release_idle busy=%b skew_a=%h exp busy=0 skew_a=0", busy, skew_a);
    end
  endtask

  task automatic test_skew();
    logic [31:0] exp;
    int e1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'h04030201;
    push_beat(s_data);
    tick();
    pop_expected(cyc, exp);
    checks++;
    if (skew_a !== exp) begin failures++; $display("[TB] FAIL skew_first cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
    checks++;
    if (arr_load !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL skew_stream load/busy/ready got=%b%b%b exp=111", arr_load, busy, s_ready);
    end
    s_data = 32'h08070605;
    s_last = 1'b1;
    push_beat(s_data);
    tick();
    e1      = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    for (int k = 0; k < 10; k++) begin
      pop_expected(cyc, exp);
      checks++;
      if (skew_a !== exp) begin failures++; $display("[TB] FAIL skew_lane cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
      checks++;
      if (done !== (cyc == e1 + 6)) begin failures++; $display("[TB] FAIL skew_done cyc=%0d got=%b", cyc, done); end
      checks++;
      if (busy !== (cyc <= e1 + 6) || arr_load !== (cyc <= e1 + 6)) begin
        failures++; $display("[TB] FAIL skew_busy_load cyc=%0d got=%b%b", cyc, busy, arr_load);
      end
      checks++;
      if (s_ready !== (cyc > e1 + 6)) begin failures++; $display("[TB] FAIL skew_ready cyc=%0d got=%b", cyc, s_ready); end
      tick();
    end
  endtask

  task automatic test_bubble();
    logic [31:0] exp;
    int eb;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'h11223344;
    push_beat(s_data);
    tick();
    s_valid = 1'b0;
    s_data  = 32'hBADBADBA;
    for (int k = 0; k < 2; k++) begin
      pop_expected(cyc, exp);
      checks++;
      if (skew_a !== exp) begin failures++; $display("[TB] FAIL bubble_gap cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
      tick();
    end
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'h55667788;
    push_beat(s_data);
    tick();
    eb      = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pop_expected(cyc, exp);
      checks++;
      if (skew_a !== exp) begin failures++; $display("[TB] FAIL bubble_lane cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
      checks++;
      if (done !== (cyc == eb + 6)) begin failures++; $display("[TB] FAIL bubble_done cyc=%0d got=%b", cyc, done); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic        exp_ready;
    logic        exp_load;
    int e1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 32'hDEADBEEF;
    push_beat(s_data);
    tick();
    s_data = 32'hCAFEF00D;
    s_last = 1'b1;
    push_beat(s_data);
    tick();
    e1     = cyc;
    s_data = 32'hA55A3CC3;
    for (int k = 0; k < 17; k++) begin
      exp_ready = !((cyc <= e1 + 6) || (cyc >= e1 + 8 && cyc <= e1 + 14));
      exp_load  = (cyc <= e1 + 6) || (cyc >= e1 + 8 && cyc <= e1 + 14);
      pop_expected(cyc, exp);
      checks++;
      if (skew_a !== exp) begin failures++; $display("[TB] FAIL b2b_lane cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
      checks++;
      if (s_ready !== exp_ready) begin failures++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready); end
      checks++;
      if (arr_load !== exp_load) begin failures++; $display("[TB] FAIL b2b_load cyc=%0d got=%b exp=%b", cyc, arr_load, exp_load); end
      checks++;
      if (done !== (cyc == e1 + 6 || cyc == e1 + 14)) begin
        failures++; $display("[TB] FAIL b2b_done cyc=%0d got=%b", cyc, done);
      end
      if (cyc == e1 + 7) push_beat(s_data);
      if (cyc == e1 + 8) s_valid = 1'b0;
      tick();
    end
    s_last = 1'b0;
  endtask

  task automatic test_single_vector();
    logic [31:0] exp;
    int e;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'h0F1E2D3C;
    push_beat(s_data);
    tick();
    e       = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pop_expected(cyc, exp);
      checks++;
      if (skew_a !== exp) begin failures++; $display("[TB] FAIL single_lane cyc=%0d got=%h exp=%h", cyc, skew_a, exp); end
      checks++;
      if (done !== (cyc == e + 6)) begin failures++; $display("[TB] FAIL single_done cyc=%0d got=%b", cyc, done); end
      checks++;
      if (busy !== (cyc <= e + 6)) begin failures++; $display("[TB] FAIL single_busy cyc=%0d got=%b", cyc, busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    int e;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 32'h99AABBCC;
    tick();
    e       = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (cyc < e + 4) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (skew_a !== 32'h0) begin failures++; $display("[TB] FAIL middrain_skew_a got=%h exp=0", skew_a); end
    checks++;
    if (arr_load !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL middrain_load_busy got=%b%b exp=00", arr_load, busy);
    end
    sb.delete();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin failures++; $display("[TB] FAIL middrain_no_done cyc=%0d got=%b exp=0", cyc, done); end
    end
    test_skew();
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    test_reset();
    test_skew();
    test_bubble();
    test_back_to_back();
    test_single_vector();
    test_reset_mid_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
